// File: rtl/pdu_release_sched_pkg.sv
// rtl/pdu_release_sched_pkg.sv - shared types and constants for the PDU release scheduler
package pdu_release_sched_pkg;
  localparam int ACTION_WIDTH = 2;
  localparam int PDUID_WIDTH  = 8;
  localparam int SIZE_WIDTH   = 16;

  localparam logic [ACTION_WIDTH-1:0] ACTION_FWD  = 2'd0;
  localparam logic [ACTION_WIDTH-1:0] ACTION_DROP = 2'd1;

  typedef struct packed {
    logic [ACTION_WIDTH-1:0] action;
    logic [PDUID_WIDTH-1:0]  pdu_id;
    logic [4:0]              flits;
    logic [SIZE_WIDTH-1:0]   pdu_size;
  } pdu_metadata_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [5:0] empty;
  } flit_tag_t;

  typedef struct packed {
    logic [511:0] data;
    flit_tag_t    tag;
  } skid_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FREE} state_t;

  // Unused bytes in the last 64-byte flit; full flits wrap to zero.
  function automatic logic [5:0] eop_empty(input logic [5:0] size_lsb);
    return 6'd0 - size_lsb;
  endfunction
endpackage

// File: rtl/pdu_release_sched_sc_fifo.sv
// rtl/pdu_release_sched_sc_fifo.sv - synchronous FIFO with registered occupancy
module sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/pdu_release_sched.sv
// rtl/pdu_release_sched.sv - buffers PDU metadata, fetches/forwards or drops flits, frees PDU IDs
module pdu_release_sched
  import pdu_release_sched_pkg::*;
#(
  parameter int META_DEPTH    = 512,
  parameter int FLITS_PER_PDU = 32,
  parameter int RD_LAT        = 2,
  parameter int SKID_DEPTH    = 4,
  localparam int IDX_W = $clog2(FLITS_PER_PDU)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  pdu_metadata_t                pdumeta_cpu_data,
  input  logic                         pdumeta_cpu_valid,
  output logic [9:0]                   pdumeta_cnt,
  output logic                         meta_overflow,
  output logic                         pkt_buf_rd_en,
  output logic [PDUID_WIDTH+IDX_W-1:0] pkt_buf_rd_addr,
  input  logic [511:0]                 pkt_buf_rd_data,
  output logic [511:0]                 out_data,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [5:0]                   out_empty,
  input  logic                         out_ready,
  output logic [PDUID_WIDTH-1:0]       free_id_data,
  output logic                         free_id_valid,
  input  logic                         free_id_ready
);
  localparam int SKID_CW = $clog2(SKID_DEPTH + 1);
  localparam int CNT_W   = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PDUID_WIDTH-1:0]  r_pdu_id;
  logic [IDX_W:0]          r_count;
  logic [IDX_W-1:0]        r_flit_idx;
  logic [5:0]              r_empty;
  logic                    r_overflow;
  logic [RD_LAT-1:0]       r_tag_vld;
  flit_tag_t               r_tag [RD_LAT];

  pdu_metadata_t           w_head;
  logic                    w_meta_full;
  logic                    w_meta_empty;
  logic                    w_meta_pop;
  skid_entry_t             w_skid_wr_data;
  skid_entry_t             w_skid_head;
  logic                    w_skid_full;
  logic                    w_skid_empty;
  logic [SKID_CW-1:0]      w_skid_cnt;
  logic [CNT_W-1:0]        w_inflight;
  logic                    w_can_issue;
  logic                    w_last;
  logic                    w_rd_en;
  logic                    w_free_vld;
  flit_tag_t               w_new_tag;
  logic                    w_unused;

  sc_fifo #(.WIDTH($bits(pdu_metadata_t)), .DEPTH(META_DEPTH)) u_meta_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (pdumeta_cpu_valid),
    .i_wr_data (pdumeta_cpu_data),
    .i_rd_en   (w_meta_pop),
    .o_rd_data (w_head),
    .o_full    (w_meta_full),
    .o_empty   (w_meta_empty),
    .o_count   (pdumeta_cnt)
  );

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CNT_W'(r_tag_vld[i]);
  end

  // Reserve a skid slot for every read in flight so returning data never finds the skid full.
  assign w_can_issue = (CNT_W'(w_skid_cnt) + w_inflight) < CNT_W'(SKID_DEPTH);
  assign w_last      = ({1'b0, r_flit_idx} == (r_count - 1'b1));
  assign w_new_tag   = '{sop: (r_flit_idx == '0), eop: w_last, empty: (w_last ? r_empty : 6'd0)};

  always_comb begin
    w_state_nxt = r_state;
    w_meta_pop  = 1'b0;
    w_rd_en     = 1'b0;
    w_free_vld  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_meta_empty) begin
          w_meta_pop  = 1'b1;
          w_state_nxt = (w_head.action == ACTION_DROP) ? ST_FREE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_can_issue) begin
          w_rd_en = 1'b1;
          if (w_last) w_state_nxt = ST_FREE;
        end
      end
      ST_FREE: begin
        w_free_vld = 1'b1;
        if (free_id_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pdu_id   <= '0;
      r_count    <= '0;
      r_flit_idx <= '0;
      r_empty    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (pdumeta_cpu_valid && w_meta_full) r_overflow <= 1'b1;
      if (w_meta_pop) begin
        r_pdu_id   <= w_head.pdu_id;
        r_count    <= (w_head.flits == '0) ? (IDX_W+1)'(FLITS_PER_PDU) : (IDX_W+1)'(w_head.flits);
        r_empty    <= eop_empty(w_head.pdu_size[5:0]);
        r_flit_idx <= '0;
      end else if (w_rd_en) begin
        r_flit_idx <= r_flit_idx + 1'b1;
      end
    end
  end

  // Only the valids are reset: data returning after a reset has no tag and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_tag[0] <= w_new_tag;
    for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
  end

  assign w_skid_wr_data = '{data: pkt_buf_rd_data, tag: r_tag[RD_LAT-1]};

  sc_fifo #(.WIDTH($bits(skid_entry_t)), .DEPTH(SKID_DEPTH)) u_skid_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_tag_vld[RD_LAT-1]),
    .i_wr_data (w_skid_wr_data),
    .i_rd_en   (out_valid && out_ready),
    .o_rd_data (w_skid_head),
    .o_full    (w_skid_full),
    .o_empty   (w_skid_empty),
    .o_count   (w_skid_cnt)
  );

  assign pkt_buf_rd_en   = w_rd_en;
  assign pkt_buf_rd_addr = {r_pdu_id, r_flit_idx};
  assign out_valid       = !w_skid_empty;
  assign out_data        = w_skid_head.data;
  assign out_sop         = out_valid && w_skid_head.tag.sop;
  assign out_eop         = out_valid && w_skid_head.tag.eop;
  assign out_empty       = out_valid ? w_skid_head.tag.empty : 6'd0;
  assign free_id_valid   = w_free_vld;
  assign free_id_data    = r_pdu_id;
  assign meta_overflow   = r_overflow;
  assign w_unused        = ^{w_skid_full, w_head.pdu_size[SIZE_WIDTH-1:6]};
endmodule

// File: tb/tb_pdu_release_sched.sv
// tb/tb_pdu_release_sched.sv - scoreboard bench for pdu_release_sched
module tb_pdu_release_sched;
  import pdu_release_sched_pkg::*;

  localparam int AW = PDUID_WIDTH + 5;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  logic                   clk = 1'b0;
  logic                   rst;
  pdu_metadata_t          pdumeta_cpu_data;
  logic                   pdumeta_cpu_valid;
  logic [9:0]             pdumeta_cnt;
  logic                   meta_overflow;
  logic                   pkt_buf_rd_en;
  logic [AW-1:0]          pkt_buf_rd_addr;
  logic [511:0]           pkt_buf_rd_data;
  logic [511:0]           out_data;
  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic [5:0]             out_empty;
  logic                   out_ready;
  logic [PDUID_WIDTH-1:0] free_id_data;
  logic                   free_id_valid;
  logic                   free_id_ready;

  int n_tests = 0;
  int n_fail  = 0;

  flit_t                  exp_flit_q[$];
  logic [AW-1:0]          exp_addr_q[$];
  logic [PDUID_WIDTH-1:0] exp_free_q[$];

  int    issued, xfered, max_outst;
  logic  prev_stall;
  flit_t prev_flit;
  logic [AW-1:0] r_mem_addr;

  pdu_release_sched dut (
    .clk               (clk),
    .rst               (rst),
    .pdumeta_cpu_data  (pdumeta_cpu_data),
    .pdumeta_cpu_valid (pdumeta_cpu_valid),
    .pdumeta_cnt       (pdumeta_cnt),
    .meta_overflow     (meta_overflow),
    .pkt_buf_rd_en     (pkt_buf_rd_en),
    .pkt_buf_rd_addr   (pkt_buf_rd_addr),
    .pkt_buf_rd_data   (pkt_buf_rd_data),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_sop           (out_sop),
    .out_eop           (out_eop),
    .out_empty         (out_empty),
    .out_ready         (out_ready),
    .free_id_data      (free_id_data),
    .free_id_valid     (free_id_valid),
    .free_id_ready     (free_id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] flit_pattern(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {19'h5A3C1, a};
    return {16{w}};
  endfunction

  // Packet buffer: data for the address strobed in cycle t is presented in cycle t+2.
  always @(posedge clk) begin
    r_mem_addr      <= pkt_buf_rd_addr;
    pkt_buf_rd_data <= flit_pattern(r_mem_addr);
  end

  always @(negedge clk) begin
    logic [AW-1:0]          ea;
    logic [PDUID_WIDTH-1:0] ef;
    flit_t                  got;
    flit_t                  ex;
    got = {out_data, out_sop, out_eop, out_empty};
    if (rst) begin
      issued     = 0;
      xfered     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (!out_valid || got !== prev_flit) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b sop=%0b eop=%0b empty=%0d w0=%h, required held valid flit sop=%0b eop=%0b empty=%0d w0=%h",
                   out_valid, out_sop, out_eop, out_empty, out_data[31:0],
                   prev_flit.sop, prev_flit.eop, prev_flit.empty, prev_flit.data[31:0]);
        end
      end
      if (pkt_buf_rd_en) begin
        issued++;
        n_tests++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_addr: unexpected read at %0d, required no read", pkt_buf_rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (pkt_buf_rd_addr !== ea) begin
            n_fail++;
            $display("FAIL rd_addr: got %0d, required %0d", pkt_buf_rd_addr, ea);
          end
        end
      end
      if (out_valid && out_ready) begin
        xfered++;
        n_tests++;
        if (exp_flit_q.size() == 0) begin
          n_fail++;
          $display("FAIL egress: unexpected flit w0=%h, required no flit", out_data[31:0]);
        end else begin
          ex = exp_flit_q.pop_front();
          if (got !== ex) begin
            n_fail++;
            $display("FAIL egress: got w0=%h sop=%0b eop=%0b empty=%0d, required w0=%h sop=%0b eop=%0b empty=%0d",
                     out_data[31:0], out_sop, out_eop, out_empty,
                     ex.data[31:0], ex.sop, ex.eop, ex.empty);
          end
        end
      end
      if (free_id_valid && free_id_ready) begin
        n_tests++;
        if (exp_free_q.size() == 0) begin
          n_fail++;
          $display("FAIL free_id: unexpected release of %0d, required none", free_id_data);
        end else begin
          ef = exp_free_q.pop_front();
          if (free_id_data !== ef) begin
            n_fail++;
            $display("FAIL free_id: got %0d, required %0d", free_id_data, ef);
          end
        end
      end
      if (issued - xfered > max_outst) max_outst = issued - xfered;
      prev_stall = out_valid && !out_ready;
      prev_flit  = got;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_queues();
    exp_flit_q.delete();
    exp_addr_q.delete();
    exp_free_q.delete();
  endtask

  task automatic send_rec(input logic [1:0] act, input logic [7:0] id, input logic [4:0] fl,
                          input logic [15:0] sz, input bit track);
    int            n;
    int            e;
    logic [AW-1:0] a;
    flit_t         f;
    pdumeta_cpu_data  = '{action: act, pdu_id: id, flits: fl, pdu_size: sz};
    pdumeta_cpu_valid = 1'b1;
    if (track) begin
      if (act != ACTION_DROP) begin
        n = (fl == 0) ? 32 : int'(fl);
        e = (64 - (int'(sz) % 64)) % 64;
        for (int i = 0; i < n; i++) begin
          a       = AW'(int'(id) * 32 + i);
          f.data  = flit_pattern(a);
          f.sop   = (i == 0);
          f.eop   = (i == n - 1);
          f.empty = (i == n - 1) ? 6'(e) : 6'd0;
          exp_addr_q.push_back(a);
          exp_flit_q.push_back(f);
        end
      end
      exp_free_q.push_back(id);
    end
    tick();
    pdumeta_cpu_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit timed_out);
    for (int k = 0; k < 3000; k++) begin
      if (exp_flit_q.size() == 0 && exp_addr_q.size() == 0 && exp_free_q.size() == 0) break;
      tick();
    end
    timed_out = !(exp_flit_q.size() == 0 && exp_addr_q.size() == 0 && exp_free_q.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pdumeta_cpu_valid = 1'b0;
    pdumeta_cpu_data  = '0;
    out_ready     = 1'b1;
    free_id_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    n_tests++; if (out_sop !== 1'b0)       begin n_fail++; $display("FAIL reset_out_sop: got %0b, required 0", out_sop); end
    n_tests++; if (out_eop !== 1'b0)       begin n_fail++; $display("FAIL reset_out_eop: got %0b, required 0", out_eop); end
    n_tests++; if (pkt_buf_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b, required 0", pkt_buf_rd_en); end
    n_tests++; if (free_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_free_valid: got %0b, required 0", free_id_valid); end
    n_tests++; if (meta_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b, required 0", meta_overflow); end
    n_tests++; if (pdumeta_cnt !== 10'd0)  begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", pdumeta_cnt); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_forward();
    bit to;
    send_rec(ACTION_FWD, 8'd3, 5'd2, 16'd100, 1'b1);
    wait_drain(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL single_fwd_drain: pending flits=%0d reads=%0d frees=%0d, required 0", exp_flit_q.size(), exp_addr_q.size(), exp_free_q.size()); end
  endtask

  task automatic test_drop();
    bit to;
    int k;
    send_rec(ACTION_DROP, 8'd7, 5'd4, 16'd256, 1'b1);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (free_id_valid) break;
      @(posedge clk);
      #1;
    end
    n_tests++; if (k > 3) begin n_fail++; $display("FAIL drop_free_latency: cycles=%0d, required <=3", k); end
    tick();
    wait_drain(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL drop_drain: pending frees=%0d, required 0", exp_free_q.size()); end
  endtask

  task automatic test_full_pdu();
    bit to;
    int sop_c;
    int eop_c;
    int nx;
    sop_c = -1;
    eop_c = -1;
    nx    = 0;
    send_rec(ACTION_FWD, 8'd5, 5'd0, 16'd2048, 1'b1);
    for (int c = 0; c < 300 && eop_c < 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        nx++;
        if (out_sop) sop_c = c;
        if (out_eop) eop_c = c;
      end
      @(posedge clk);
      #1;
    end
    n_tests++; if (eop_c < 0 || sop_c < 0 || eop_c - sop_c != 31 || nx != 32) begin n_fail++; $display("FAIL full_pdu_bubbles: sop_cycle=%0d eop_cycle=%0d flits=%0d, required span 31 and 32 flits", sop_c, eop_c, nx); end
    wait_drain(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL full_pdu_drain: pending flits=%0d, required 0", exp_flit_q.size()); end
  endtask

  task automatic test_backpressure();
    bit to;
    max_outst = 0;
    send_rec(ACTION_FWD, 8'd9, 5'd10, 16'd600, 1'b1);
    for (int c = 0; c < 400; c++) begin
      if (exp_flit_q.size() == 0) break;
      out_ready = (c % 4 == 0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL backpressure_drain: pending flits=%0d, required 0", exp_flit_q.size()); end
    n_tests++; if (max_outst > 4) begin n_fail++; $display("FAIL backpressure_occupancy: max outstanding=%0d, required <=4", max_outst); end
  endtask

  task automatic test_overflow();
    free_id_ready = 1'b0;
    send_rec(ACTION_DROP, 8'd1, 5'd1, 16'd0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 512; i++) begin
      pdumeta_cpu_data  = '{action: ACTION_DROP, pdu_id: 8'(i), flits: 5'd1, pdu_size: 16'd64};
      pdumeta_cpu_valid = 1'b1;
      tick();
    end
    pdumeta_cpu_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (pdumeta_cnt !== 10'd512) begin n_fail++; $display("FAIL occupancy_full: got %0d, required 512", pdumeta_cnt); end
    n_tests++; if (meta_overflow !== 1'b0)  begin n_fail++; $display("FAIL overflow_early: got %0b, required 0", meta_overflow); end
    tick();
    send_rec(ACTION_DROP, 8'd2, 5'd1, 16'd0, 1'b0);
    @(negedge clk);
    n_tests++; if (meta_overflow !== 1'b1)  begin n_fail++; $display("FAIL overflow_set: got %0b, required 1", meta_overflow); end
    n_tests++; if (pdumeta_cnt !== 10'd512) begin n_fail++; $display("FAIL occupancy_after_overflow: got %0d, required 512", pdumeta_cnt); end
    tick();
    rst = 1'b1;
    flush_queues();
    tick();
    rst = 1'b0;
    free_id_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (meta_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %0b, required 0", meta_overflow); end
    n_tests++; if (pdumeta_cnt !== 10'd0)  begin n_fail++; $display("FAIL occupancy_clear: got %0d, required 0", pdumeta_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    bit to;
    out_ready     = 1'b0;
    free_id_ready = 1'b1;
    send_rec(ACTION_FWD, 8'd11, 5'd20, 16'd1280, 1'b1);
    repeat (6) tick();
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fetch_head: out_valid=%0b, required 1", out_valid); end
    tick();
    rst = 1'b1;
    flush_queues();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_reset_out_valid: got %0b, required 0", out_valid); end
    n_tests++; if (pdumeta_cnt !== 10'd0)  begin n_fail++; $display("FAIL mid_reset_cnt: got %0d, required 0", pdumeta_cnt); end
    n_tests++; if (free_id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_free_valid: got %0b, required 0", free_id_valid); end
    tick();
    out_ready = 1'b1;
    send_rec(ACTION_FWD, 8'd12, 5'd3, 16'd130, 1'b1);
    wait_drain(to);
    n_tests++; if (to) begin n_fail++; $display("FAIL post_reset_drain: pending flits=%0d reads=%0d frees=%0d, required 0", exp_flit_q.size(), exp_addr_q.size(), exp_free_q.size()); end
  endtask

  initial begin
    max_outst = 0;
    test_reset();
    test_single_forward();
    test_drop();
    test_full_pdu();
    test_backpressure();
    test_overflow();
    test_reset_mid_fetch();
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
